// File: rtl/fft8_pkg.sv
// Shared constants and helpers for the 8-point FFT output path.
// The beat-to-bin tables describe how the SDF pipeline pairs bins
// on each output beat.
package fft8_pkg;

  localparam int FFT_N      = 8;
  localparam int LOG2N      = 3;
  localparam int BEATS      = 4;
  localparam int BEAT_W     = 2;
  localparam int DW_DEFAULT = 16;

  // Reverse the three index bits: b2 b1 b0 -> b0 b1 b2.
  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] x);
    return {x[0], x[1], x[2]};
  endfunction

  // Beat b carries bin bitrev3(2b) on X1 and bin bitrev3(2b+1) on X2.
  localparam logic [LOG2N-1:0] X1_BIN [BEATS] = '{
    bitrev3(3'd0), bitrev3(3'd2), bitrev3(3'd4), bitrev3(3'd6)
  };
  localparam logic [LOG2N-1:0] X2_BIN [BEATS] = '{
    bitrev3(3'd1), bitrev3(3'd3), bitrev3(3'd5), bitrev3(3'd7)
  };

  localparam logic [LOG2N-1:0]  LAST_IDX  = 3'd7;
  localparam logic [BEAT_W-1:0] LAST_BEAT = 2'd3;

endpackage

// File: rtl/fft8_bank.sv
// One frame of storage: eight complex bins packed as {real, imag}.
// Two bins are written per cycle at independent addresses; a single
// combinational read port serves the natural-order readout.
module fft8_bank
  import fft8_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic              c,
  input  logic              rst_n,
  input  logic              we,
  input  logic [LOG2N-1:0]  waddr1,
  input  logic [2*DW-1:0]   wdata1,
  input  logic [LOG2N-1:0]  waddr2,
  input  logic [2*DW-1:0]   wdata2,
  input  logic [LOG2N-1:0]  raddr,
  output logic [2*DW-1:0]   rdata
);

  logic [2*DW-1:0] mem [FFT_N];

  // Store both bins of an accepted beat; reset wipes the whole frame.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FFT_N; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr1] <= wdata1;
      mem[waddr2] <= wdata2;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft8_out_reorder.sv
// Turns the bit-reversed, two-bins-per-beat FFT output into a natural
// order stream of one bin per cycle. Two banks ping-pong so a new frame
// can be written while the previous one drains.
module fft8_out_reorder
  import fft8_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic                 c,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] X1r,
  input  logic signed [DW-1:0] X1i,
  input  logic signed [DW-1:0] X2r,
  input  logic signed [DW-1:0] X2i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic [LOG2N-1:0]     out_idx,
  output logic                 out_last,
  output logic                 ovf
);

  logic [1:0]        full, full_n;
  logic              wbank, wbank_n;
  logic              rbank, rbank_n;
  logic [BEAT_W-1:0] beat_cnt, beat_n;
  logic [LOG2N-1:0]  rd_cnt, rd_n;
  logic              wr_acc, rd_acc;
  logic [LOG2N-1:0]  waddr1, waddr2;
  logic [2*DW-1:0]   rdata0, rdata1, rd_word;

  assign wr_acc = in_valid & in_ready;
  assign rd_acc = out_valid & out_ready;
  assign waddr1 = X1_BIN[beat_cnt];
  assign waddr2 = X2_BIN[beat_cnt];

  fft8_bank #(.DW(DW)) bank0 (
    .c      (c),
    .rst_n  (rst_n),
    .we     (wr_acc & ~wbank),
    .waddr1 (waddr1),
    .wdata1 ({X1r, X1i}),
    .waddr2 (waddr2),
    .wdata2 ({X2r, X2i}),
    .raddr  (rd_cnt),
    .rdata  (rdata0)
  );

  fft8_bank #(.DW(DW)) bank1 (
    .c      (c),
    .rst_n  (rst_n),
    .we     (wr_acc & wbank),
    .waddr1 (waddr1),
    .wdata1 ({X1r, X1i}),
    .waddr2 (waddr2),
    .wdata2 ({X2r, X2i}),
    .raddr  (rd_cnt),
    .rdata  (rdata1)
  );

  // Next-state for both sides; a completing write and a freeing read
  // always touch different banks, so their flag updates never collide.
  always_comb begin
    full_n  = full;
    wbank_n = wbank;
    rbank_n = rbank;
    beat_n  = beat_cnt;
    rd_n    = rd_cnt;
    if (wr_acc) begin
      beat_n = beat_cnt + 1'b1;
      if (beat_cnt == LAST_BEAT) begin
        full_n[wbank] = 1'b1;
        wbank_n       = ~wbank;
      end
    end
    if (rd_acc) begin
      rd_n = rd_cnt + 1'b1;
      if (rd_cnt == LAST_IDX) begin
        full_n[rbank] = 1'b0;
        rbank_n       = ~rbank;
      end
    end
  end

  // Register the flags, pointers and the write-side handshake.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 2'b00;
      wbank    <= 1'b0;
      rbank    <= 1'b0;
      beat_cnt <= '0;
      rd_cnt   <= '0;
      in_ready <= 1'b1;
      ovf      <= 1'b0;
    end else begin
      full     <= full_n;
      wbank    <= wbank_n;
      rbank    <= rbank_n;
      beat_cnt <= beat_n;
      rd_cnt   <= rd_n;
      in_ready <= ~full_n[wbank_n];
      ovf      <= ovf | (in_valid & ~in_ready);
    end
  end

  assign rd_word   = rbank ? rdata1 : rdata0;
  assign out_valid = full[rbank];
  assign out_r     = rd_word[2*DW-1:DW];
  assign out_i     = rd_word[DW-1:0];
  assign out_idx   = rd_cnt;
  assign out_last  = (rd_cnt == LAST_IDX);

endmodule
